// File: rtl/mc_fetch_unit.sv
// Multicycle fetch/memory front end: owns PC, IR and MDR and sequences one
// outstanding memory request at a time, stalling the control unit until ack.
module mc_fetch_unit #(
  parameter int                   BIT_WIDTH = 32,
  parameter logic [BIT_WIDTH-1:0] RESET_PC  = 32'h0040_0000
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 PCWrite,
  input  logic                 Branch,
  input  logic                 PCSrc,
  input  logic                 IorD,
  input  logic                 IRWrite,
  input  logic                 MemWrite,
  input  logic                 Zero,
  input  logic [BIT_WIDTH-1:0] ALUResult,
  input  logic [BIT_WIDTH-1:0] ALUOut,
  input  logic [BIT_WIDTH-1:0] WriteData,
  input  logic [BIT_WIDTH-1:0] mem_rdata,
  input  logic                 mem_ack,
  output logic                 mem_req,
  output logic                 mem_we,
  output logic [BIT_WIDTH-1:0] mem_addr,
  output logic [BIT_WIDTH-1:0] mem_wdata,
  output logic [BIT_WIDTH-1:0] PC,
  output logic [BIT_WIDTH-1:0] Instr,
  output logic [BIT_WIDTH-1:0] Data,
  output logic [5:0]           Op,
  output logic [5:0]           Funct,
  output logic                 stall,
  output logic                 align_err
);

  typedef enum logic [1:0] {IDLE, BUSY_RD, BUSY_WR} state_t;

  state_t               state_q;
  logic [BIT_WIDTH-1:0] pc_q, instr_q, data_q, mem_addr_q, mem_wdata_q;
  logic                 mem_req_q, mem_we_q, align_err_q;

  logic                 busy, pcen, misaligned;
  logic [BIT_WIDTH-1:0] pc_d, cap_addr, addr_d;

  // The control unit holds its strobes while stalled, so a PC update asked for
  // alongside a fetch is naturally deferred to the ack cycle when stall drops.
  always_comb begin
    busy       = (state_q != IDLE);
    stall      = ((state_q == IDLE) && (IRWrite || MemWrite)) || (busy && !mem_ack);
    pcen       = (PCWrite || (Branch && !Zero)) && !stall;
    pc_d       = PCSrc ? ALUOut : ALUResult;
    cap_addr   = (!IRWrite && IorD) ? ALUOut : pc_q;
    misaligned = (cap_addr[1:0] != 2'b00);
    addr_d     = {cap_addr[BIT_WIDTH-1:2], 2'b00};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      pc_q        <= RESET_PC;
      instr_q     <= '0;
      data_q      <= '0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      align_err_q <= 1'b0;
    end else begin
      if (pcen) pc_q <= pc_d;
      case (state_q)
        IDLE: begin
          if (IRWrite) begin
            mem_addr_q  <= addr_d;
            mem_we_q    <= 1'b0;
            mem_req_q   <= 1'b1;
            align_err_q <= align_err_q | misaligned;
            state_q     <= BUSY_RD;
          end else if (MemWrite) begin
            mem_addr_q  <= addr_d;
            mem_wdata_q <= WriteData;
            mem_we_q    <= 1'b1;
            mem_req_q   <= 1'b1;
            align_err_q <= align_err_q | misaligned;
            state_q     <= BUSY_WR;
          end
        end
        BUSY_RD: begin
          if (mem_ack) begin
            instr_q   <= mem_rdata;
            data_q    <= mem_rdata;
            mem_req_q <= 1'b0;
            state_q   <= IDLE;
          end
        end
        BUSY_WR: begin
          if (mem_ack) begin
            mem_req_q <= 1'b0;
            mem_we_q  <= 1'b0;
            state_q   <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign PC        = pc_q;
  assign Instr     = instr_q;
  assign Data      = data_q;
  assign Op        = instr_q[31:26];
  assign Funct     = instr_q[5:0];
  assign align_err = align_err_q;

endmodule

// File: tb/tb_mc_fetch_unit.sv
// Directed bench for mc_fetch_unit: fetches, stores, branches, alignment, reset.
module tb_mc_fetch_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        PCWrite, Branch, PCSrc, IorD, IRWrite, MemWrite, Zero;
  logic [31:0] ALUResult, ALUOut, WriteData, mem_rdata;
  logic        mem_ack;
  logic        mem_req, mem_we, stall, align_err;
  logic [31:0] mem_addr, mem_wdata, PC, Instr, Data;
  logic [5:0]  Op, Funct;

  int total = 0;
  int bad   = 0;

  mc_fetch_unit #(.BIT_WIDTH(32), .RESET_PC(32'h0040_0000)) dut (
    .clk(clk), .rst(rst),
    .PCWrite(PCWrite), .Branch(Branch), .PCSrc(PCSrc), .IorD(IorD),
    .IRWrite(IRWrite), .MemWrite(MemWrite), .Zero(Zero),
    .ALUResult(ALUResult), .ALUOut(ALUOut), .WriteData(WriteData),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .PC(PC), .Instr(Instr), .Data(Data), .Op(Op), .Funct(Funct),
    .stall(stall), .align_err(align_err)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    PCWrite = 0; Branch = 0; PCSrc = 0; IorD = 0; IRWrite = 0; MemWrite = 0;
    Zero = 0; ALUResult = 0; ALUOut = 0; WriteData = 0; mem_rdata = 0; mem_ack = 0;
  endtask

  task automatic do_reset();
    rst = 1;
    step();
    step();
    rst = 0;
    #1;
  endtask

  task automatic test_reset();
    clear_inputs();
    do_reset();
    total++; if (PC !== 32'h0040_0000) begin bad++; $display("FAIL reset_pc got=%h exp=%h", PC, 32'h0040_0000); end
    total++; if (Instr !== 32'h0 || Data !== 32'h0) begin bad++; $display("FAIL reset_ir got=%h/%h exp=0", Instr, Data); end
    total++; if ({mem_req, mem_we, align_err, stall} !== 4'b0) begin bad++; $display("FAIL reset_flags got=%b exp=0000", {mem_req, mem_we, align_err, stall}); end
    total++; if (mem_addr !== 32'h0 || mem_wdata !== 32'h0) begin bad++; $display("FAIL reset_mem got=%h/%h exp=0", mem_addr, mem_wdata); end
    $display("reset: PC=%h Instr=%h", PC, Instr);
  endtask

  // Fetch at PC=0x00400000 with a PC+4 update; ack after 'waits' busy cycles.
  task automatic test_fetch(input int waits, input int exp_stall, input logic [31:0] rdata);
    int scnt = 0;
    IRWrite = 1; PCWrite = 1; PCSrc = 0; ALUResult = 32'h0040_0004; mem_ack = 0;
    #1;
    if (stall) scnt++;
    step();
    total++; if (mem_req !== 1'b1 || mem_we !== 1'b0 || mem_addr !== 32'h0040_0000) begin
      bad++; $display("FAIL fetch_req got req=%b we=%b addr=%h exp 1/0/00400000", mem_req, mem_we, mem_addr); end
    for (int w = 0; w < waits; w++) begin
      #1;
      if (stall) scnt++;
      total++; if (PC !== 32'h0040_0000 || mem_addr !== 32'h0040_0000 || mem_req !== 1'b1) begin
        bad++; $display("FAIL fetch_wait%0d got PC=%h addr=%h req=%b exp 00400000/00400000/1", w, PC, mem_addr, mem_req); end
      step();
    end
    mem_ack = 1; mem_rdata = rdata;
    #1;
    if (stall) scnt++;
    step();
    mem_ack = 0; IRWrite = 0; PCWrite = 0;
    total++; if (scnt !== exp_stall) begin bad++; $display("FAIL fetch_stall_cycles got=%0d exp=%0d", scnt, exp_stall); end
    total++; if (Instr !== rdata || Data !== rdata) begin bad++; $display("FAIL fetch_instr got=%h/%h exp=%h", Instr, Data, rdata); end
    total++; if (PC !== 32'h0040_0004) begin bad++; $display("FAIL fetch_pc got=%h exp=00400004", PC); end
    total++; if (mem_req !== 1'b0) begin bad++; $display("FAIL fetch_req_drop got=%b exp=0", mem_req); end
    step();
    total++; if (PC !== 32'h0040_0004) begin bad++; $display("FAIL fetch_pc_once got=%h exp=00400004", PC); end
    $display("fetch waits=%0d: Instr=%h Op=%0d PC=%h stall_cycles=%0d", waits, Instr, Op, PC, scnt);
  endtask

  task automatic test_store();
    MemWrite = 1; IorD = 1; ALUOut = 32'h1001_0008; WriteData = 32'hDEAD_BEEF;
    #1;
    total++; if (stall !== 1'b1) begin bad++; $display("FAIL store_stall got=%b exp=1", stall); end
    step();
    total++; if (mem_req !== 1'b1 || mem_we !== 1'b1 || mem_addr !== 32'h1001_0008 || mem_wdata !== 32'hDEAD_BEEF) begin
      bad++; $display("FAIL store_req got req=%b we=%b addr=%h wd=%h exp 1/1/10010008/deadbeef", mem_req, mem_we, mem_addr, mem_wdata); end
    mem_ack = 1; mem_rdata = 32'h1234_5678;
    step();
    mem_ack = 0; MemWrite = 0; IorD = 0;
    total++; if (Instr !== 32'h8C08_0000 || mem_req !== 1'b0 || mem_we !== 1'b0) begin
      bad++; $display("FAIL store_done got Instr=%h req=%b we=%b exp 8c080000/0/0", Instr, mem_req, mem_we); end
    total++; if (align_err !== 1'b0) begin bad++; $display("FAIL store_align got=%b exp=0", align_err); end
    $display("store: addr=%h wdata=%h Instr=%h", mem_addr, mem_wdata, Instr);
  endtask

  task automatic test_bne();
    Branch = 1; PCSrc = 1; Zero = 0; ALUOut = 32'h0040_0020; ALUResult = 32'h1111_1110;
    #1;
    total++; if (stall !== 1'b0) begin bad++; $display("FAIL bne_stall got=%b exp=0", stall); end
    step();
    total++; if (PC !== 32'h0040_0020) begin bad++; $display("FAIL bne_taken got=%h exp=00400020", PC); end
    Zero = 1; ALUOut = 32'h0040_0040;
    step();
    total++; if (PC !== 32'h0040_0020) begin bad++; $display("FAIL bne_not_taken got=%h exp=00400020", PC); end
    Branch = 0; PCSrc = 0; Zero = 0;
    $display("bne: PC=%h", PC);
  endtask

  task automatic test_irwrite_wins();
    IRWrite = 1; MemWrite = 1; IorD = 1; ALUOut = 32'h1001_0010; WriteData = 32'h5555_5555;
    step();
    total++; if (mem_we !== 1'b0 || mem_addr !== 32'h0040_0020) begin
      bad++; $display("FAIL both_strobes got we=%b addr=%h exp 0/00400020", mem_we, mem_addr); end
    mem_ack = 1; mem_rdata = 32'h0000_0020;
    step();
    mem_ack = 0; IRWrite = 0; MemWrite = 0; IorD = 0;
    total++; if (Instr !== 32'h0000_0020 || Funct !== 6'h20 || Op !== 6'h00) begin
      bad++; $display("FAIL both_instr got Instr=%h Funct=%h Op=%h exp 00000020/20/00", Instr, Funct, Op); end
    $display("irwrite_wins: Instr=%h Funct=%h", Instr, Funct);
  endtask

  task automatic test_idle_ack();
    mem_ack = 1; mem_rdata = 32'hFFFF_FFFF;
    step();
    mem_ack = 0;
    total++; if (Instr !== 32'h0000_0020 || Data !== 32'h0000_0020 || mem_req !== 1'b0 || PC !== 32'h0040_0020) begin
      bad++; $display("FAIL idle_ack got Instr=%h Data=%h req=%b PC=%h exp 00000020/00000020/0/00400020", Instr, Data, mem_req, PC); end
    $display("idle_ack: Instr=%h", Instr);
  endtask

  task automatic test_misaligned();
    MemWrite = 1; IorD = 1; ALUOut = 32'h1001_0006; WriteData = 32'h0;
    step();
    total++; if (mem_addr !== 32'h1001_0004 || align_err !== 1'b1) begin
      bad++; $display("FAIL misaligned got addr=%h err=%b exp 10010004/1", mem_addr, align_err); end
    mem_ack = 1;
    step();
    mem_ack = 0; MemWrite = 0; IorD = 0;
    step();
    step();
    total++; if (align_err !== 1'b1) begin bad++; $display("FAIL align_sticky got=%b exp=1", align_err); end
    $display("misaligned: addr=%h align_err=%b", mem_addr, align_err);
  endtask

  task automatic test_reset_mid();
    IRWrite = 1; PCWrite = 1; ALUResult = 32'h0040_0024;
    step();
    total++; if (mem_req !== 1'b1) begin bad++; $display("FAIL mid_busy got=%b exp=1", mem_req); end
    #2 rst = 1;
    #1;
    total++; if (PC !== 32'h0040_0000 || mem_req !== 1'b0 || align_err !== 1'b0) begin
      bad++; $display("FAIL async_rst got PC=%h req=%b err=%b exp 00400000/0/0", PC, mem_req, align_err); end
    clear_inputs();
    #1 rst = 0;
    step();
    mem_ack = 1; mem_rdata = 32'hABCD_EF01;
    step();
    mem_ack = 0;
    #1;
    total++; if (PC !== 32'h0040_0000 || Instr !== 32'h0 || mem_req !== 1'b0 || stall !== 1'b0) begin
      bad++; $display("FAIL late_ack got PC=%h Instr=%h req=%b stall=%b exp 00400000/0/0/0", PC, Instr, mem_req, stall); end
    $display("reset_mid: PC=%h Instr=%h", PC, Instr);
  endtask

  initial begin
    rst = 1;
    clear_inputs();
    test_reset();
    test_fetch(1, 2, 32'h3C01_1001);
    total++; if (Op !== 6'd15) begin bad++; $display("FAIL fetch_op got=%0d exp=15", Op); end
    do_reset();
    test_fetch(3, 4, 32'h8C08_0000);
    test_store();
    test_bne();
    test_irwrite_wins();
    test_idle_ack();
    test_misaligned();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
